minterm_sweep_ctrl: RTL and testbench
=====================================

Name: minterm_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 4-input combinational function block (inputs A..D, output F).
- Steps the 4-bit input vector through 0..15 and waits a programmable settle time per vector.
- Samples F into a 16-bit observed minterm mask and compares it bit-wise against an expected mask.
- Reports pass/fail, the mismatch count and the first failing index.
- Sits beside the function block as its on-chip self-test driver.

Parameters:
SETTLE_CYCLES, 2, cycles input vector is held before F is sampled (legal range 1..15).
EXP_MASK, 16'hDF03, expected minterm mask; bit k = F for ABCD = k. The default encodes m(0,1,8,9,10,11,12,14,15).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  sampled in IDLE only; launches a sweep.
abort  input  1  synchronous; terminates an active sweep.
f_in  input  1  F output of the function block.
abcd  output  4  vector to the block: abcd[3]=A, [2]=B, [1]=C, [0]=D.
busy  output  1  high from the cycle after start until the sweep ends or is aborted.
done  output  1  one-cycle pulse when a full sweep completes.
pass  output  1  observed mask == EXP_MASK; valid from done and held until the next start.
mask  output  16  observed minterm mask.
mismatch_count  output  5  number of differing bits, 0..16.
fail_valid  output  1  at least one mismatch recorded.
first_fail_idx  output  4  lowest index that mismatched; valid when fail_valid = 1.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All of abcd, busy, done, pass, mask, mismatch_count, fail_valid, first_fail_idx and the internal idx/settle counters are 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 and abort=0:
  - idx, abcd, settle_cnt, mask, mismatch_count, fail_valid, first_fail_idx and pass are cleared.
  - busy goes to 1 and the state moves to SETTLE.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYCLES-1, the next state is SAMPLE.
  - abcd is stable for the entire SETTLE and SAMPLE period.
- SAMPLE (one cycle):
  - mask[idx] is loaded from f_in.
  - If f_in != EXP_MASK[idx]: mismatch_count increments. If fail_valid = 0, first_fail_idx is set to idx and fail_valid to 1.
  - If idx == 15, go to DONE.
  - Otherwise idx and abcd advance to idx+1, settle_cnt clears and the state returns to SETTLE.
- DONE (one cycle):
  - done = 1 and busy = 0.
  - pass is set to (mismatch_count == 0), using the final updated count.
  - The next state is IDLE.
- Timing with start captured at edge 0, S = SETTLE_CYCLES:
  - Vector k is sampled in cycle (k+1)(S+1).
  - done is high in cycle 16(S+1)+1; with the default S = 2 this is cycle 49.
- After completion, abcd holds 4'hF. mask and the result outputs hold until the next start.
- start while busy (SETTLE/SAMPLE/DONE): ignored, with no restart and no effect on counters.
- abort=1 in SETTLE/SAMPLE:
  - Next state is IDLE with busy = 0. done does not pulse and pass stays 0.
  - mask, mismatch_count and fail fields keep their partial values. abcd holds its value.
  - The SAMPLE-cycle update is suppressed when abort=1 in that same cycle.
- abort in DONE: ignored; done still pulses.
- abort together with start in IDLE: abort wins and the block stays IDLE.
- Reset asserted mid-sweep: immediate return to reset values. No done pulse.
- mismatch_count cannot overflow, since 5 bits cover a maximum of 16.

Test Plan:
1. Golden model of m(0,1,8,9,10,11,12,14,15) on f_in, default parameters, start pulse -> abcd steps 0..15, each value held 3 cycles. done at cycle 49, mask = 16'hDF03, pass = 1, mismatch_count = 0, fail_valid = 0.
2. f_in tied to 0 -> mask = 16'h0000, mismatch_count = 9, fail_valid = 1, first_fail_idx = 0, pass = 0.
3. f_in = inverted golden model -> mask = 16'h20FC, mismatch_count = 16, first_fail_idx = 0, pass = 0. Repeat with only minterm 12 flipped -> mismatch_count = 1, first_fail_idx = 12.
4. start re-pulsed at cycle 10 of a sweep -> ignored; done still at cycle 49 with identical results. SETTLE_CYCLES = 1 build -> done at cycle 33.
5. abort while abcd = 5 -> busy drops the next cycle, no done pulse, pass = 0, mask[15:5] = 0. A following start runs a full clean sweep -> pass = 1.
6. rst_n pulled low asynchronously mid-cycle while abcd = 9 -> all outputs are 0 immediately. After release, the block stays IDLE until start.

Source files
------------

// File: rtl/minterm_sweep_ctrl.sv
// Self-test sequencer: sweeps ABCD through 0..15 and checks F against an expected minterm mask.
// Latency: 16*(SETTLE_CYCLES+1)+1 cycles from start capture to the done pulse.
// Backpressure: none; start is honoured only in IDLE, abort ends an active sweep early.
module minterm_sweep_ctrl #(
  parameter int          SETTLE_CYCLES = 2,        // legal range 1..15
  parameter logic [15:0] EXP_MASK      = 16'hDF03  // bit k = expected F for ABCD = k
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mask,
  output logic [4:0]  mismatch_count,
  output logic        fail_valid,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q;
  logic [3:0] settle_cnt_q;
  logic       launch;
  logic       sample_en;
  logic       sample_miss;

  // The vector driven to the block is always the index under test.
  assign abcd = idx_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle strobes; abort beats start and suppresses sampling.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    sample_en   = 1'b0;
    sample_miss = (f_in != EXP_MASK[idx_q]);
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          launch  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort)                           state_d = IDLE;
        else if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sample_en = 1'b1;
          state_d   = (idx_q == 4'd15) ? DONE : SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: sweep counters, observed mask and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= 4'd0;
      settle_cnt_q   <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mask           <= 16'd0;
      mismatch_count <= 5'd0;
      fail_valid     <= 1'b0;
      first_fail_idx <= 4'd0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        idx_q          <= 4'd0;
        settle_cnt_q   <= 4'd0;
        busy           <= 1'b1;
        pass           <= 1'b0;
        mask           <= 16'd0;
        mismatch_count <= 5'd0;
        fail_valid     <= 1'b0;
        first_fail_idx <= 4'd0;
      end
      if ((state_q == SETTLE || state_q == SAMPLE) && abort) begin
        busy <= 1'b0;
      end
      if (state_q == SETTLE && !abort) begin
        settle_cnt_q <= settle_cnt_q + 4'd1;
      end
      if (sample_en) begin
        mask[idx_q] <= f_in;
        if (sample_miss) begin
          mismatch_count <= mismatch_count + 5'd1;
          if (!fail_valid) begin
            first_fail_idx <= idx_q;
            fail_valid     <= 1'b1;
          end
        end
        // The last vector stays on abcd after the sweep completes.
        if (idx_q != 4'd15) begin
          idx_q        <= idx_q + 4'd1;
          settle_cnt_q <= 4'd0;
        end
      end
      // mismatch_count already holds the final total when DONE is reached.
      if (state_q == DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (mismatch_count == 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Bench for minterm_sweep_ctrl: function-block model on f_in, vector table of full sweeps,
// scoreboard of expected abcd sequence, hand sequences for abort, reset and short-settle build.
// No backpressure in this block; all waits are cycle-bounded.
module tb_minterm_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, f_in;
  logic [3:0]  abcd;
  logic        busy, done, pass, fail_valid;
  logic [15:0] mask;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;

  logic        start1, abort1, f_in1;
  logic [3:0]  abcd1;
  logic        busy1, done1, pass1, fail_valid1;
  logic [15:0] mask1;
  logic [4:0]  mismatch_count1;
  logic [3:0]  first_fail_idx1;

  int tests = 0;
  int fails = 0;
  int f_mode = 0;
  logic [15:0] gold;

  always #5 clk = ~clk;

  minterm_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .abcd(abcd), .busy(busy), .done(done), .pass(pass), .mask(mask),
    .mismatch_count(mismatch_count), .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
  );

  minterm_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f_in1),
    .abcd(abcd1), .busy(busy1), .done(done1), .pass(pass1), .mask(mask1),
    .mismatch_count(mismatch_count1), .fail_valid(fail_valid1), .first_fail_idx(first_fail_idx1)
  );

  // Function-block model: 0 golden, 1 stuck-at-0, 2 inverted, 3 golden with minterm 12 flipped.
  function automatic logic model_f(input int mode, input logic [15:0] g, input logic [3:0] v);
    case (mode)
      0:       return g[v];
      1:       return 1'b0;
      2:       return ~g[v];
      3:       return g[v] ^ (v == 4'd12);
      default: return 1'b0;
    endcase
  endfunction

  always_comb f_in  = model_f(f_mode, gold, abcd);
  always_comb f_in1 = model_f(0, gold, abcd1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: expected abcd values are queued at launch and popped whenever a new vector appears.
  logic [3:0] exp_q[$];
  bit         prev_busy = 1'b0;
  logic [3:0] prev_abcd = 4'd0;
  logic [3:0] mon_e;
  int         hold = 0;

  always @(negedge clk) begin
    if (busy && (!prev_busy || abcd != prev_abcd)) begin
      if (prev_busy) check("vector_hold", hold, 3);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL abcd_unexpected: got %0d, expected no new vector", abcd);
      end else begin
        mon_e = exp_q.pop_front();
        check("abcd_seq", abcd, mon_e);
      end
      hold = 1;
    end else if (busy) begin
      hold++;
    end
    prev_busy = busy;
    prev_abcd = abcd;
  end

  task automatic fill_queue();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
  endtask

  // Launch a sweep from a negedge; returns the cycle index (start edge = 0) at which done is seen.
  task automatic run_sweep(input bit repulse, output int dc);
    fill_queue();
    dc = -1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done) begin
        dc = n;
        break;
      end
      start = (repulse && n == 10);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int          mode;
    logic [15:0] exp_mask;
    int          exp_cnt;
    logic        exp_fv;
    logic [3:0]  exp_ffi;
    logic        exp_pass;
    bit          repulse;
  } vec_t;

  vec_t vecs[5];
  int   minterms[9] = '{0, 1, 8, 9, 10, 11, 12, 14, 15};

  initial begin
    int dc;
    int seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    gold = 16'd0;
    foreach (minterms[i]) gold[minterms[i]] = 1'b1;

    vecs[0] = '{0, 16'hDF03, 0,  1'b0, 4'd0,  1'b1, 1'b0};
    vecs[1] = '{1, 16'h0000, 9,  1'b1, 4'd0,  1'b0, 1'b0};
    vecs[2] = '{2, 16'h20FC, 16, 1'b1, 4'd0,  1'b0, 1'b0};
    vecs[3] = '{3, 16'hCF03, 1,  1'b1, 4'd12, 1'b0, 1'b0};
    vecs[4] = '{0, 16'hDF03, 0,  1'b0, 4'd0,  1'b1, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_abcd", abcd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mask", mask, 0);
    check("rst_mismatch", mismatch_count, 0);
    check("rst_fail_valid", fail_valid, 0);
    check("rst_first_fail", first_fail_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweeps from the vector table.
    for (int i = 0; i < 5; i++) begin
      f_mode = vecs[i].mode;
      run_sweep(vecs[i].repulse, dc);
      check("done_cycle", dc, 49);
      check("mask", mask, vecs[i].exp_mask);
      check("mismatch_count", mismatch_count, vecs[i].exp_cnt);
      check("fail_valid", fail_valid, vecs[i].exp_fv);
      check("first_fail_idx", first_fail_idx, vecs[i].exp_ffi);
      check("pass", pass, vecs[i].exp_pass);
      check("final_abcd", abcd, 15);
      check("busy_at_done", busy, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("pass_held", pass, vecs[i].exp_pass);
      check("queue_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);
    end

    // Short-settle build.
    dc = -1;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done1) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
    check("s1_done_cycle", dc, 33);
    check("s1_pass", pass1, 1);
    check("s1_mask", mask1, 16'hDF03);

    // start together with abort in IDLE: abort wins, previous results untouched.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_pass", pass, 1);
    @(negedge clk);
    check("start_abort_busy2", busy, 0);

    // Abort while abcd = 5.
    f_mode = 0;
    fill_queue();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      if (abcd == 4'd5) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_5", seen, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);
    check("abort_pass", pass, 0);
    check("abort_mask_hi", mask[15:5], 0);
    check("abort_mask_lo", mask[4:0], 5'b00011);
    check("abort_abcd", abcd, 5);
    check("abort_mismatch", mismatch_count, 0);
    exp_q.delete();
    run_sweep(1'b0, dc);
    check("post_abort_done", dc, 49);
    check("post_abort_pass", pass, 1);
    check("post_abort_mask", mask, 16'hDF03);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-sweep at abcd = 9 with a stuck-at-0 block.
    f_mode = 1;
    fill_queue();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      if (abcd == 4'd9) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach_9", seen, 1);
    check("pre_rst_mismatch", mismatch_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_abcd", abcd, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_pass", pass, 0);
    check("arst_mask", mask, 0);
    check("arst_mismatch", mismatch_count, 0);
    check("arst_fail_valid", fail_valid, 0);
    check("arst_first_fail", first_fail_idx, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("post_rst_idle", seen, 0);
    check("post_rst_abcd", abcd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
